// File: rtl/fft_input_loader_if.sv
// Sample-in / frame-out bus between the upstream sample source, the
// bit-reverse frame loader and the FFT core.
interface fft_input_loader_if #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
);
  logic                     flush;
  logic [15:0]              in_sample;
  logic                     in_valid;
  logic                     in_ready;
  logic                     frame_valid;
  logic                     frame_ready;
  logic                     start;
  logic [LOG_2_WIDTH-1:0]   sample_idx;
  logic [16*D_WIDTH-1:0]    output_sig;

  modport master (
    output flush, in_sample, in_valid, frame_ready,
    input  in_ready, frame_valid, start, sample_idx, output_sig
  );

  modport slave (
    input  flush, in_sample, in_valid, frame_ready,
    output in_ready, frame_valid, start, sample_idx, output_sig
  );
endinterface

// File: rtl/fft_input_loader.sv
// Collects D_WIDTH samples into a frame buffer and hands the frame to the FFT.
// Define FFT_LOADER_BITREV_EN for bit-reversed slot order (DIT input); natural order otherwise.
module fft_loader_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module fft_input_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  fft_input_loader_if.slave bus
);
  typedef enum logic {FILL, FULL} state_t;

  state_t                       state;
  logic [LOG_2_WIDTH-1:0]       wr_cnt;
  logic [LOG_2_WIDTH-1:0]       wr_slot;
  logic                         in_ready_r, frame_valid_r, start_r;
  logic                         accept;
  logic [D_WIDTH-1:0]           we;
  logic [D_WIDTH-1:0][15:0]     slot_q;

  // A flush in the same cycle as a valid sample drops that sample.
  assign accept = in_ready_r && bus.in_valid && !bus.flush;

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    wr_slot = '0;
    for (int b = 0; b < LOG_2_WIDTH; b++)
      wr_slot[b] = wr_cnt[LOG_2_WIDTH-1-b];
  end
`else
  assign wr_slot = wr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      wr_cnt        <= '0;
      in_ready_r    <= 1'b1;
      frame_valid_r <= 1'b0;
      start_r       <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state)
        FILL: begin
          if (bus.flush) begin
            wr_cnt <= '0;
          end else if (bus.in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LOG_2_WIDTH'(D_WIDTH-1)) begin
              state         <= FULL;
              in_ready_r    <= 1'b0;
              frame_valid_r <= 1'b1;
              start_r       <= 1'b1;
            end
          end
        end
        FULL: begin
          // Frame is held intact until consumed; flush is deliberately ignored here.
          if (bus.frame_ready) begin
            state         <= FILL;
            wr_cnt        <= '0;
            in_ready_r    <= 1'b1;
            frame_valid_r <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < D_WIDTH; k++) begin : g_slot
    assign we[k] = accept && (wr_slot == LOG_2_WIDTH'(k));
    fft_loader_slot u_slot (
      .clk (clk),
      .rst (rst),
      .we  (we[k]),
      .d   (bus.in_sample),
      .q   (slot_q[k])
    );
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.start       = start_r;
  assign bus.sample_idx  = wr_cnt;
  assign bus.output_sig  = slot_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// Directed + random bench for fft_input_loader against a frame-level reference model.
module tb_fft_input_loader;
  localparam int N  = 64;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fft_input_loader_if #(.D_WIDTH(N), .LOG_2_WIDTH(LW)) bus ();

  fft_input_loader #(.D_WIDTH(N), .LOG_2_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: buffer contents, fill count, and whether a frame is held.
  logic [15:0] m_mem [N];
  int          m_cnt;
  bit          m_full;
  bit          m_start;

  function automatic int slot_of(int c);
    int r;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < LW; b++) r = r * 2 + ((c >> b) & 1);
`else
    r = c;
`endif
    return r;
  endfunction

  function automatic logic [16*N-1:0] m_frame();
    logic [16*N-1:0] f;
    for (int k = 0; k < N; k++) f[16*k +: 16] = m_mem[k];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [16*N-1:0] obs, input logic [16*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".in_ready"},    (16*N)'(bus.in_ready),    (16*N)'(!m_full));
    chk({tag, ".frame_valid"}, (16*N)'(bus.frame_valid), (16*N)'(m_full));
    chk({tag, ".start"},       (16*N)'(bus.start),       (16*N)'(m_start));
    chk({tag, ".sample_idx"},  (16*N)'(bus.sample_idx),  (16*N)'(m_cnt));
    chk({tag, ".output_sig"},  bus.output_sig,           m_frame());
  endtask

  // One clock: drive inputs, advance the model, sample outputs just after the edge.
  task automatic step(input bit r, input bit v, input logic [15:0] s, input bit fl, input bit fr);
    rst = r; bus.in_valid = v; bus.in_sample = s; bus.flush = fl; bus.frame_ready = fr;
    @(posedge clk);
    m_start = 0;
    if (r) begin
      for (int k = 0; k < N; k++) m_mem[k] = '0;
      m_cnt = 0; m_full = 0;
    end else if (!m_full) begin
      if (fl) m_cnt = 0;
      else if (v) begin
        m_mem[slot_of(m_cnt)] = s;
        m_cnt++;
        if (m_cnt == N) begin m_cnt = 0; m_full = 1; m_start = 1; end
      end
    end else if (fr) begin
      m_full = 0; m_cnt = 0;
    end
    #1;
  endtask

  logic [16*N-1:0] held;
  int              nacc;

  initial begin
    rst = 1'b1; bus.in_valid = 0; bus.in_sample = '0; bus.flush = 0; bus.frame_ready = 0;
    for (int k = 0; k < N; k++) m_mem[k] = 16'hDEAD;
    m_cnt = 0; m_full = 0; m_start = 0;

    // Reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_all("reset");
    chk("reset.output_zero", bus.output_sig, '0);
    step(0, 0, 0, 0, 0);
    chk_all("idle");

    // Back-to-back ramp frame
    for (int i = 0; i < N; i++) begin
      step(0, 1, 16'(i), 0, 0);
      if (i == N-1) begin
        chk("ramp.start", (16*N)'(bus.start), 1);
        chk("ramp.frame_valid", (16*N)'(bus.frame_valid), 1);
      end else if (i % 8 == 3) chk_all("ramp.fill");
    end
    chk_all("ramp.done");
`ifdef FFT_LOADER_BITREV_EN
    chk("ramp.slot0",  (16*N)'(bus.output_sig[16*0  +: 16]), 16'h0000);
    chk("ramp.slot32", (16*N)'(bus.output_sig[16*32 +: 16]), 16'h0001);
    chk("ramp.slot16", (16*N)'(bus.output_sig[16*16 +: 16]), 16'h0002);
    chk("ramp.slot48", (16*N)'(bus.output_sig[16*48 +: 16]), 16'h0003);
    chk("ramp.slot63", (16*N)'(bus.output_sig[16*63 +: 16]), 16'h003F);
`else
    for (int k = 0; k < N; k++)
      chk($sformatf("ramp.nat_slot%0d", k), (16*N)'(bus.output_sig[16*k +: 16]), (16*N)'(k));
`endif
    step(0, 1, 16'h1234, 0, 0);
    chk("ramp.start_drop", (16*N)'(bus.start), 0);
    chk("ramp.in_ready_low", (16*N)'(bus.in_ready), 0);

    // Hold with in_valid asserted: no writes
    held = m_frame();
    for (int i = 0; i < 10; i++) step(0, 1, 16'($urandom), 0, 0);
    chk_all("hold");
    chk("hold.stable", bus.output_sig, held);
    step(0, 1, 16'hBEEF, 1, 1);   // handshake; flush ignored in FULL, sample not taken
    chk_all("handshake");
    chk("handshake.idx0", (16*N)'(bus.sample_idx), 0);

    // Bubbles, then flush with a valid sample
    for (int i = 0; i < 10; i++) step(0, (i % 2) == 0, 16'($urandom), 0, 1);
    chk("bubble.idx5", (16*N)'(bus.sample_idx), 5);
    chk_all("bubble");
    step(0, 1, 16'hF1F1, 1, 0);
    chk_all("flush");
    chk("flush.idx0", (16*N)'(bus.sample_idx), 0);

    // Random frame with bubbles after the flush
    nacc = 0;
    for (int i = 0; i < 400 && nacc < N; i++) begin
      bit v;
      v = ($urandom % 3) != 0;
      if (v) nacc++;
      step(0, v, 16'($urandom), 0, 0);
    end
    chk("rand_frame.valid", (16*N)'(bus.frame_valid), 1);
    chk_all("rand_frame");
    step(0, 0, 0, 0, 1);
    chk_all("rand_frame.ack");

    // Reset mid-fill at sample_idx 20
    for (int i = 0; i < 20; i++) step(0, 1, 16'($urandom), 0, 0);
    chk("midfill.idx20", (16*N)'(bus.sample_idx), 20);
    step(1, 1, 16'hAAAA, 0, 0);
    chk_all("rst_fill");
    chk("rst_fill.zero", bus.output_sig, '0);

    // Reset while a frame is held
    for (int i = 0; i < N; i++) step(0, 1, 16'($urandom), 0, 0);
    chk("prefull.valid", (16*N)'(bus.frame_valid), 1);
    step(1, 0, 0, 0, 1);
    chk_all("rst_full");
    chk("rst_full.zero", bus.output_sig, '0);

    // Random soak with frame_ready tied high: minimum frame period
    for (int i = 0; i < N; i++) step(0, 1, 16'($urandom), 0, 1);
    chk("tied.start", (16*N)'(bus.start), 1);
    step(0, 1, 16'h5555, 0, 1);
    chk_all("tied.accept");
    for (int i = 0; i < 600; i++) begin
      step(0, ($urandom % 4) != 0, 16'($urandom), ($urandom % 40) == 0, ($urandom % 3) == 0);
      chk_all("soak");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
